uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Shares one uart_tx instance among N byte requesters.
- Round-robin arbitration picks one requester at a time.
- Sequences the uart_tx load/enable protocol per frame: one-cycle ldtx with tx_en, tx_en held for the whole frame, then an inter-frame gap so the downstream uart_rx can catch up.
- Sits between the requesting client blocks and uart_tx, entirely in the txclk (bit-clock) domain.

Parameters:
- N_REQ, 4, number of requesters (1..16).
- FRAME_BITS, 10, txclk cycles tx_en stays high after the load cycle (start + 8 data + stop).
- GAP_CYCLES, 8, minimum txclk cycles with tx_en low between frames.

Ports:
- txclk  in  1  bit clock, one bit per cycle.
- txreset  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester send request; level, held until ack.
- req_data  in  8*N_REQ  byte for requester i at [8i+7:8i].
- ack  out  N_REQ  one-cycle pulse: the byte of requester i has been captured.
- done  out  1  one-cycle pulse at the end of a frame (entry to GAP).
- done_id  out  4  requester index of the frame just completed; valid with done.
- busy  out  1  high in any state other than IDLE.
- ldtx  out  1  to uart_tx, load strobe.
- tx_data  out  8  to uart_tx, byte to send.
- tx_en  out  1  to uart_tx, transmit enable.
- tx_empty  in  1  from uart_tx, high when the shift register is idle.

Behaviour:
- All outputs are registered.
- Reset is asynchronous: every output goes to 0, state to IDLE, counter to 0, RR pointer to 0.
- States and transitions:
  - IDLE:
    - If req is nonzero, the RR arbiter picks the first set bit at or above ptr, wrapping to 0.
    - On the edge: tx_data<=req_data[winner], ldtx<=1, tx_en<=1, ack[winner]<=1, cur_id<=winner, ptr<=(winner+1) mod N_REQ, go to LOAD.
  - LOAD (1 cycle):
    - On the edge: ldtx<=0, ack<=0, tx_en stays 1, cnt<=FRAME_BITS-1, go to SEND.
  - SEND:
    - tx_en=1 throughout; cnt decrements each cycle.
    - When cnt==0: tx_en<=0, done<=1, done_id<=cur_id, cnt<=GAP_CYCLES-1, go to GAP.
    - tx_en is therefore high for exactly 1+FRAME_BITS cycles.
  - GAP:
    - done clears after one cycle; cnt decrements and saturates at 0.
    - When cnt==0 and tx_empty==1, go to IDLE.
    - If tx_empty==0 at cnt==0, stay in GAP until it rises.
- Latency:
  - A req seen in IDLE puts ldtx/tx_en on the bus at the next edge.
  - Back-to-back frames start at minimum every 1+FRAME_BITS+GAP_CYCLES+1 = 20 cycles with the defaults.
- req is sampled only in IDLE:
  - A req raised during LOAD, SEND or GAP waits.
  - A req dropped before ack is never sent; no error is raised.
- Simultaneous requests: exactly one ack per frame. Under continuous full load, requesters are served in strict rotation (fairness).
- tx_data is held stable from LOAD until the next LOAD; it changes only in IDLE→LOAD.
- txreset mid-frame aborts immediately: tx_en/ldtx go to 0, no done pulse, the frame is lost, ptr returns to 0.
- N_REQ==1: the arbiter degenerates to a passthrough and ptr stays 0.
- Counter width: clog2(max(FRAME_BITS,GAP_CYCLES)+1).

Decomposition:
- Package uart_sched_pkg holds:
  - state enum {IDLE, LOAD, SEND, GAP};
  - constants DEF_FRAME_BITS=10, DEF_GAP_CYCLES=8, MAX_REQ=16.
- Sub-module rr_arbiter (N_REQ):
  - Combinational: inputs req and ptr, outputs one-hot grant and binary index.
  - The pointer register lives in uart_tx_sched.

Test Plan:
- Single request: req=0001, req_data[7:0]=0xA5 → next edge ldtx=1, tx_en=1, tx_data=0xA5, ack=0001 for 1 cycle. tx_en is high for exactly 11 cycles, done=1 with done_id=0, and uart_rx output = 0xA5.
- Contention: req=1010 held, data 0x3C/0x81 on ports 1/3 → port 1 (0x3C) sent first, then port 3 (0x81). ack pulses exactly once each, and frame start edges are 20 cycles apart.
- Fairness: req=1111 held for 8 frames → done_id sequence 0,1,2,3,0,1,2,3. No frame overlap, and tx_en is low for ≥8 cycles between frames.
- Gap stretch: force tx_empty=0 for 5 cycles after GAP count expiry → IDLE entry is delayed 5 cycles and no ldtx appears while tx_empty=0.
- Reset mid-SEND: assert txreset 4 cycles into SEND → tx_en, ldtx, ack, done and busy go to 0 asynchronously. After release, req=0100 is served by port 2 (ptr reset to 0).
- Dropped request: req pulsed for 1 cycle during SEND then low → no ack and no extra frame; busy returns to 0 after GAP.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the uart_tx frame scheduler.
// Holds the FSM state encoding and the counter sizing helper.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int DEF_FRAME_BITS = 10;
    localparam int DEF_GAP_CYCLES = 8;
    localparam int MAX_REQ        = 16;

    // One counter serves both the frame and the gap phase, so it must hold the larger.
    function automatic int cnt_width(input int frame_bits, input int gap_cycles);
        int m;
        m = (frame_bits > gap_cycles) ? frame_bits : gap_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Client-side request bus and uart_tx-side load/enable bus of the scheduler.
// master = clients plus uart_tx model, slave = the scheduler itself.
interface uart_tx_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic               done;
    logic [3:0]         done_id;
    logic               busy;
    logic               ldtx;
    logic [7:0]         tx_data;
    logic               tx_en;
    logic               tx_empty;

    modport master (
        output req, req_data, tx_empty,
        input  ack, done, done_id, busy, ldtx, tx_data, tx_en
    );

    modport slave (
        input  req, req_data, tx_empty,
        output ack, done, done_id, busy, ldtx, tx_data, tx_en
    );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping to 0.
// The pointer register is owned by the caller.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PTR_W-1:0] o_idx
);

    logic w_found;
    int   w_cand;

    // NOTE: every variable written here gets a default first, otherwise a
    // path with no request would hold the old value and infer a latch.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N_REQ) begin
                w_cand = w_cand - N_REQ;
            end
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = PTR_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx among N_REQ byte requesters: round-robin pick, one-cycle
// load strobe, tx_en held for the frame, then an enforced inter-frame gap.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic            txclk,
    input  logic            txreset,
    uart_tx_sched_if.slave  bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = cnt_width(FRAME_BITS, GAP_CYCLES);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(N_REQ - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_cur_id;
    logic             r_ldtx;
    logic             r_tx_en;
    logic [7:0]       r_tx_data;
    logic [N_REQ-1:0] r_ack;
    logic             r_done;
    logic [3:0]       r_done_id;
    logic             r_busy;

    logic [N_REQ-1:0] w_grant;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_ptr_next;
    logic [7:0]       w_sel_data;
    logic             w_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_any      = |bus.req;
    assign w_ptr_next = (w_idx == PTR_LAST) ? '0 : w_idx + PTR_W'(1);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) == w_idx) begin
                w_sel_data = bus.req_data[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge txclk or posedge txreset) begin
        if (txreset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_cur_id  <= '0;
            r_ldtx    <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_data <= '0;
            r_ack     <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_tx_data <= w_sel_data;
                        r_ldtx    <= 1'b1;
                        r_tx_en   <= 1'b1;
                        r_ack     <= w_grant;
                        r_cur_id  <= w_idx;
                        r_ptr     <= w_ptr_next;
                        r_busy    <= 1'b1;
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    r_ldtx  <= 1'b0;
                    r_ack   <= '0;
                    r_cnt   <= FRAME_LAST;
                    r_state <= SEND;
                end
                SEND: begin
                    if (r_cnt == '0) begin
                        r_tx_en   <= 1'b0;
                        r_done    <= 1'b1;
                        r_done_id <= 4'(r_cur_id);
                        r_cnt     <= GAP_LAST;
                        r_state   <= GAP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    r_done <= 1'b0;
                    // The gap only ends once uart_tx reports its shifter idle.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (bus.tx_empty) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ldtx    = r_ldtx;
    assign bus.tx_en   = r_tx_en;
    assign bus.tx_data = r_tx_data;
    assign bus.ack     = r_ack;
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed stimulus pushes expected
// frames into a queue, an independent monitor pops and compares per ldtx/done.
module tb_uart_tx_sched;

    localparam int N_REQ      = 4;
    localparam int FRAME_BITS = 10;
    localparam int GAP_CYCLES = 8;
    localparam int FRAME_LEN  = 1 + FRAME_BITS;
    localparam int PERIOD     = 1 + FRAME_BITS + GAP_CYCLES + 1;

    typedef struct {
        logic [3:0] id;
        logic [7:0] data;
    } exp_t;

    logic txclk;
    logic txreset;

    int   tests     = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   frames    = 0;
    bit   stim_done = 0;
    exp_t exp_q[$];
    int   starts[$];

    uart_tx_sched_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_sched #(
        .N_REQ      (N_REQ),
        .FRAME_BITS (FRAME_BITS),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .txclk   (txclk),
        .txreset (txreset),
        .bus     (bus.slave)
    );

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    always @(posedge txclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        bus.req_data[8*i +: 8] = v;
    endtask

    task automatic expect_frame(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = 4'(id);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Runs until n frames have started; optionally drops each request on its ack.
    task automatic run_frames(input int n, input bit drop);
        int seen;
        seen = 0;
        for (int c = 0; c < 100 * n && seen < n; c++) begin
            tick();
            if (bus.ldtx) begin
                starts.push_back(cyc);
                seen++;
            end
            if (drop) bus.req = bus.req & ~bus.ack;
        end
        check("frames_started", seen, n);
    endtask

    task automatic wait_done();
        for (int c = 0; c < 100 && !bus.done; c++) tick();
        check("done_seen", bus.done, 1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100 && bus.busy; c++) tick();
        check("idle_reached", bus.busy, 0);
    endtask

    task automatic monitor();
        exp_t cur;
        bit   cur_valid = 0;
        bit   have_prev = 0;
        int   en_len    = 0;
        int   low_len   = 0;
        forever begin
            @(negedge txclk);
            if (txreset) begin
                cur_valid = 0;
                have_prev = 0;
                en_len    = 0;
                low_len   = 0;
            end else begin
                if (bus.ldtx) begin
                    frames++;
                    check("ldtx_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        cur       = exp_q.pop_front();
                        cur_valid = 1;
                        check("ack_onehot", 32'(bus.ack), 32'(1) << cur.id);
                        check("tx_data", 32'(bus.tx_data), 32'(cur.data));
                    end
                    if (have_prev) check("gap_len_ok", 32'(low_len >= GAP_CYCLES), 1);
                end else if (bus.ack != '0) begin
                    check("stray_ack", 32'(bus.ack), 0);
                end
                if (bus.done) begin
                    check("done_expected", 32'(cur_valid), 1);
                    if (cur_valid) check("done_id", 32'(bus.done_id), 32'(cur.id));
                    cur_valid = 0;
                end
                if (bus.tx_en) begin
                    en_len++;
                    low_len = 0;
                end else begin
                    if (en_len != 0) begin
                        check("tx_en_len", en_len, FRAME_LEN);
                        have_prev = 1;
                    end
                    en_len = 0;
                    low_len++;
                end
            end
        end
    endtask

    task automatic stimulus();
        txreset      = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_empty = 1'b1;
        #1;
        check("rst_ldtx",    bus.ldtx, 0);
        check("rst_tx_en",   bus.tx_en, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_ack",     bus.ack, 0);
        check("rst_done",    bus.done | 32'(bus.done_id), 0);
        check("rst_busy",    bus.busy, 0);
        repeat (2) @(posedge txclk);
        #3 txreset = 1'b0;
        tick();

        // Single request, ptr 0 -> port 0, next-edge load
        set_data(0, 8'hA5);
        bus.req = 4'b0001;
        expect_frame(0, 8'hA5);
        tick();
        check("t1_ldtx",    bus.ldtx, 1);
        check("t1_tx_en",   bus.tx_en, 1);
        check("t1_tx_data", bus.tx_data, 8'hA5);
        check("t1_ack",     bus.ack, 4'b0001);
        check("t1_busy",    bus.busy, 1);
        bus.req = '0;
        tick();
        check("t1_ack_pulse", bus.ack, 0);
        check("t1_ldtx_pulse", bus.ldtx, 0);
        wait_done();
        check("t1_done_id", bus.done_id, 0);
        tick();
        check("t1_done_pulse", bus.done, 0);
        wait_idle();

        // Contention: ports 1 and 3, ptr is 1
        set_data(1, 8'h3C);
        set_data(3, 8'h81);
        bus.req = 4'b1010;
        expect_frame(1, 8'h3C);
        expect_frame(3, 8'h81);
        starts.delete();
        run_frames(2, 1);
        if (starts.size() == 2) check("t2_spacing", starts[1] - starts[0], PERIOD);
        wait_idle();

        // Fairness under full load; ptr is back to 0
        for (int i = 0; i < N_REQ; i++) set_data(i, 8'(8'h10 + i));
        for (int f = 0; f < 8; f++) expect_frame(f % N_REQ, 8'(8'h10 + (f % N_REQ)));
        bus.req = 4'b1111;
        starts.delete();
        run_frames(8, 0);
        bus.req = '0;
        if (starts.size() == 8) check("t3_spacing", starts[7] - starts[6], PERIOD);
        wait_idle();

        // Gap stretch: tx_empty low for 5 cycles once the gap count has expired
        set_data(2, 8'h5A);
        bus.req = 4'b0100;
        expect_frame(2, 8'h5A);
        run_frames(1, 1);
        wait_done();
        repeat (GAP_CYCLES - 1) tick();
        bus.tx_empty = 1'b0;
        set_data(0, 8'h4D);
        bus.req = 4'b0001;
        expect_frame(0, 8'h4D);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_no_ldtx", bus.ldtx, 0);
            check("t4_busy_held", bus.busy, 1);
        end
        bus.tx_empty = 1'b1;
        tick();
        check("t4_idle_entry", bus.busy, 0);
        tick();
        check("t4_ldtx", bus.ldtx, 1);
        check("t4_ack", bus.ack, 4'b0001);
        bus.req = '0;
        wait_idle();

        // Reset 4 cycles into SEND; ptr was 2 after serving port 1
        set_data(1, 8'h77);
        bus.req = 4'b0010;
        expect_frame(1, 8'h77);
        run_frames(1, 1);
        repeat (5) tick();
        #3 txreset = 1'b1;
        #1;
        check("t5_rst_tx_en", bus.tx_en, 0);
        check("t5_rst_ldtx",  bus.ldtx, 0);
        check("t5_rst_ack",   bus.ack, 0);
        check("t5_rst_done",  bus.done, 0);
        check("t5_rst_busy",  bus.busy, 0);
        @(posedge txclk);
        #3 txreset = 1'b0;
        set_data(1, 8'h12);
        set_data(2, 8'hC3);
        bus.req = 4'b0110;
        expect_frame(1, 8'h12);
        expect_frame(2, 8'hC3);
        run_frames(2, 1);
        wait_idle();

        // Request pulsed during SEND and withdrawn: never served
        set_data(3, 8'hE1);
        bus.req = 4'b1000;
        expect_frame(3, 8'hE1);
        run_frames(1, 1);
        repeat (3) tick();
        set_data(0, 8'h99);
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        wait_idle();
        repeat (25) tick();
        check("t6_busy_low", bus.busy, 0);
        check("exp_queue_empty", exp_q.size(), 0);
        check("frame_count", frames, 17);
        stim_done = 1;
    endtask

    initial begin
        fork
            stimulus();
            monitor();
            begin
                #200000;
                check("watchdog_stimulus_done", 32'(stim_done), 1);
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
